// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-wire I2C-style register slave.
package i2c_pkg;
    localparam int ADDR_W    = 7;
    localparam int BYTE_W    = 8;
    localparam int REG_DEPTH = 256;
    localparam int PTR_W     = $clog2(REG_DEPTH);

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ACK_ADDR,
        REG,
        ACK_REG,
        RS_CHK,
        WDATA,
        ACK_WDATA,
        RDATA,
        MACK
    } state_t;
endpackage

// File: rtl/i2c_slave_if.sv
// Serial bus interface: the one open-drain-style data line shared by master and slave.
interface i2c_slave_if;
    wire sda;

    modport slave  (inout sda);
    modport master (inout sda);
endinterface

// File: rtl/i2c_regfile.sv
// 256x8 register file: synchronous write, combinational read, contents never reset.
module i2c_regfile
    import i2c_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [BYTE_W-1:0] rdata
);
    logic [BYTE_W-1:0] mem [REG_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/i2c_slave.sv
// Single-wire register slave: FSM, shift/bit counter and tri-state sda driver.
// Optional I2C_SLAVE_AUTOINC_EN enables pointer auto-increment and multi-byte bursts.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'h55
) (
    input logic        clk,
    input logic        rst,
    i2c_slave_if.slave bus
);
`ifdef I2C_SLAVE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    state_t            state, next_state;
    logic [BYTE_W-1:0] shreg;
    logic [2:0]        cnt;
    logic [PTR_W-1:0]  ptr;
    logic              match_q, rw_q;
    logic              sda_oe, sda_q;
    logic              next_oe, next_val;
    logic              shift_en, cnt_en, addr_done, ptr_load, ptr_inc, wr_en;
    logic              sda_in, addr_hit;
    logic [BYTE_W-1:0] rd_data;
    logic [2:0]        rd_idx;

    assign bus.sda  = sda_oe ? sda_q : 1'bz;
    assign sda_in   = bus.sda;
    assign addr_hit = (shreg[ADDR_W-1:0] == SLAVE_ADDR);
    assign rd_idx   = 3'd6 - cnt;

    i2c_regfile u_regfile (
        .clk   (clk),
        .we    (wr_en),
        .waddr (ptr),
        .wdata (shreg),
        .raddr (ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Drive values are decided on the edge entering a state and held for that whole bit.
    always_comb begin
        next_state = state;
        next_oe    = 1'b0;
        next_val   = 1'b1;
        shift_en   = 1'b0;
        cnt_en     = 1'b0;
        addr_done  = 1'b0;
        ptr_load   = 1'b0;
        ptr_inc    = 1'b0;
        wr_en      = 1'b0;
        case (state)
            IDLE:  if (!sda_in) next_state = START;
            START: next_state = sda_in ? IDLE : ADDR;
            ADDR: begin
                shift_en = 1'b1;
                cnt_en   = 1'b1;
                if (cnt == 3'd7) begin
                    addr_done  = 1'b1;
                    next_state = ACK_ADDR;
                    next_oe    = addr_hit;
                    next_val   = 1'b0;
                end
            end
            ACK_ADDR: begin
                if (!match_q) begin
                    next_state = IDLE;
                end else if (rw_q == RW_READ) begin
                    next_state = RDATA;
                    next_oe    = 1'b1;
                    next_val   = rd_data[7];
                end else begin
                    next_state = REG;
                end
            end
            REG: begin
                shift_en = 1'b1;
                cnt_en   = 1'b1;
                if (cnt == 3'd7) begin
                    ptr_load   = 1'b1;
                    next_state = ACK_REG;
                    next_oe    = 1'b1;
                    next_val   = 1'b0;
                end
            end
            ACK_REG: next_state = RS_CHK;
            RS_CHK:  next_state = sda_in ? WDATA : START;
            WDATA: begin
                shift_en = 1'b1;
                cnt_en   = 1'b1;
                if (cnt == 3'd7) begin
                    next_state = ACK_WDATA;
                    next_oe    = 1'b1;
                    next_val   = 1'b0;
                end
            end
            ACK_WDATA: begin
                wr_en      = 1'b1;
                ptr_inc    = AUTOINC;
                next_state = AUTOINC ? RS_CHK : IDLE;
            end
            RDATA: begin
                cnt_en = 1'b1;
                if (cnt == 3'd7) begin
                    ptr_inc    = AUTOINC;
                    next_state = MACK;
                end else begin
                    next_oe  = 1'b1;
                    next_val = rd_data[rd_idx];
                end
            end
            MACK: begin
                // The pointer already advanced at the end of RDATA, so rd_data is the next byte.
                if (AUTOINC && !sda_in) begin
                    next_state = RDATA;
                    next_oe    = 1'b1;
                    next_val   = rd_data[7];
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sda_oe  <= 1'b0;
            shreg   <= '0;
            cnt     <= '0;
            ptr     <= '0;
            match_q <= 1'b0;
            rw_q    <= RW_WRITE;
        end else begin
            sda_oe <= next_oe;
            if (shift_en) begin
                shreg <= {shreg[BYTE_W-2:0], sda_in};
            end
            cnt <= cnt_en ? cnt + 3'd1 : 3'd0;
            if (addr_done) begin
                match_q <= addr_hit;
                rw_q    <= sda_in;
            end
            if (ptr_load) begin
                ptr <= {shreg[BYTE_W-2:0], sda_in};
            end else if (ptr_inc) begin
                ptr <= ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        sda_q <= next_val;
    end
endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave with a queue of expected slave-driven bus cycles.
module tb_i2c_slave;
    import i2c_pkg::*;

    typedef struct {
        string tag;
        logic  oe;
        logic  val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic m_oe = 1'b1;
    logic m_val = 1'b1;
    int   compared = 0;
    int   mismatched = 0;
    exp_t sb[$];

    i2c_slave_if bus ();
    assign bus.sda = m_oe ? m_val : 1'bz;

    i2c_slave #(.SLAVE_ADDR(7'h55)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic oe, input logic val);
        exp_t e;
        e.tag = tag;
        e.oe  = oe;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        m_oe  = 1'b1;
        m_val = b;
    endtask

    task automatic send(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) drive_bit(v[i]);
    endtask

    // One bit cycle owned by the slave (or MACK, where the master drives).
    task automatic slave_cycle(input logic mdrive, input logic mval);
        exp_t e;
        @(negedge clk);
        m_oe  = mdrive;
        m_val = mval;
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 8'd1, 8'd0);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_oe"}, {7'd0, dut.sda_oe}, {7'd0, e.oe});
            if (e.oe) check(e.tag, {7'd0, bus.sda}, {7'd0, e.val});
        end
    endtask

    task automatic begin_write(input logic [7:0] reg_a);
        drive_bit(1'b0);
        drive_bit(1'b0);
        send({7'h55, RW_WRITE}, 8);
        push("ack_addr", 1'b1, 1'b0);
        slave_cycle(1'b0, 1'b0);
        send(reg_a, 8);
        push("ack_reg", 1'b1, 1'b0);
        slave_cycle(1'b0, 1'b0);
    endtask

    task automatic data_byte(input logic [7:0] d);
        drive_bit(1'b1);
        send(d, 8);
        push("ack_wdata", 1'b1, 1'b0);
        slave_cycle(1'b0, 1'b0);
    endtask

    // A 0 then 1 ends either in IDLE (single byte) or from RS_CHK (burst).
    task automatic finish_txn();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    task automatic restart_read();
        drive_bit(1'b0);
        drive_bit(1'b0);
        send({7'h55, RW_READ}, 8);
        push("ack_raddr", 1'b1, 1'b0);
        slave_cycle(1'b0, 1'b0);
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic mack);
        for (int i = 7; i >= 0; i--) push("rbit", 1'b1, exp[i]);
        push("mack", 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) slave_cycle(1'b0, 1'b0);
        slave_cycle(1'b1, mack);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_oe", {7'd0, dut.sda_oe}, 8'd0);
        check("rst_state", 8'(dut.state), 8'(IDLE));
        check("rst_ptr", dut.ptr, 8'h00);
        check("rst_cnt", {5'd0, dut.cnt}, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        drive_bit(1'b1);

        // Single-byte write
        begin_write(8'hBE);
        data_byte(8'h9A);
        finish_txn();
        check("wr_mem_be", dut.u_regfile.mem[8'hBE], 8'h9A);
        check("wr_state", 8'(dut.state), 8'(IDLE));

        // Reset, then read back through a repeated start
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        drive_bit(1'b1);
        begin_write(8'hBE);
        restart_read();
        read_byte(8'h9A, 1'b1);
        drive_bit(1'b1);
        #1;
        check("rd_state", 8'(dut.state), 8'(IDLE));

        // Address mismatch: no ACK, back to IDLE
        drive_bit(1'b0);
        drive_bit(1'b0);
        send({7'h2A, RW_WRITE}, 8);
        push("nack_addr", 1'b0, 1'b0);
        slave_cycle(1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("mm_state", 8'(dut.state), 8'(IDLE));
        drive_bit(1'b1);
        drive_bit(1'b1);
        #1;
        check("mm_oe", {7'd0, dut.sda_oe}, 8'd0);
        check("mm_mem_be", dut.u_regfile.mem[8'hBE], 8'h9A);

        // Reset during WDATA bit 4
        begin_write(8'hBE);
        drive_bit(1'b1);
        send(8'h05, 4);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_oe", {7'd0, dut.sda_oe}, 8'd0);
        check("mid_state", 8'(dut.state), 8'(IDLE));
        check("mid_ptr", dut.ptr, 8'h00);
        check("mid_shreg", dut.shreg, 8'h00);
        m_val = 1'b1;
        @(negedge clk);
        check("mid_mem_be", dut.u_regfile.mem[8'hBE], 8'h9A);
        rst = 1'b1;
        drive_bit(1'b1);
        begin_write(8'hBE);
        data_byte(8'h3C);
        finish_txn();
        check("post_mem_be", dut.u_regfile.mem[8'hBE], 8'h3C);

        // Glitch: a lone 0 in IDLE is not a START
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        #1;
        check("gl_state", 8'(dut.state), 8'(IDLE));
        check("gl_oe", {7'd0, dut.sda_oe}, 8'd0);
        drive_bit(1'b1);
        #1;
        check("gl_state2", 8'(dut.state), 8'(IDLE));

`ifdef I2C_SLAVE_AUTOINC_EN
        // Burst write wrapping 0xFF -> 0x00, then burst read
        begin_write(8'hFF);
        data_byte(8'h11);
        data_byte(8'h22);
        finish_txn();
        check("ai_mem_ff", dut.u_regfile.mem[8'hFF], 8'h11);
        check("ai_mem_00", dut.u_regfile.mem[8'h00], 8'h22);
        begin_write(8'hFF);
        restart_read();
        read_byte(8'h11, 1'b0);
        read_byte(8'h22, 1'b1);
        drive_bit(1'b1);
        #1;
        check("ai_state", 8'(dut.state), 8'(IDLE));
`endif

        check("sb_left", 8'(sb.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
